// File: rtl/hl_button_conditioner.sv
// hl_button_conditioner
//   Conditions the raw up/down push-buttons of the half-life timer into clean,
//   single-cycle count-step strobes. Each channel runs a 2-flop synchroniser,
//   then a debouncer, then rising-edge press detection, and optionally an
//   auto-repeat FSM for held buttons. When both debounced levels are high the
//   channels are mutually inhibited.
//
//   Optional feature macro: HL_AUTOREPEAT_EN
//     defined   : the WAIT/REPEAT auto-repeat FSM and its counter are built in
//     undefined : each debounced press gives exactly one pulse
//
//   Ports (top):
//     clk        in   system clock
//     reset      in   asynchronous, active-high reset
//     up_raw     in   raw up button (asynchronous)
//     down_raw   in   raw down button (asynchronous)
//     up_pulse   out  one-cycle count-up strobe
//     down_pulse out  one-cycle count-down strobe
//     up_level   out  debounced up level
//     down_level out  debounced down level
//     conflict   out  both debounced levels high

// One button channel: sync -> debounce -> press edge -> optional repeat.
//   clk, reset : clock / async active-high reset
//   raw        : raw button pin
//   inhibit    : conflict from the other channel; blocks pulses, parks FSM
//   level      : debounced level
//   pulse      : gated count strobe
module hl_btn_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
`ifdef HL_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
`endif
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic inhibit,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_m;
  logic             sync_q;
  logic [CNT_W-1:0] deb_cnt;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             rpt_pulse;

  // 2-flop synchroniser; raw is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_m <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_m <= raw;
      sync_q <= sync_m;
    end
  end

  // Debounce: the synchronised input must disagree with the accepted level
  // for DEBOUNCE_CYCLES consecutive cycles before the level flips. Any
  // agreeing sample restarts the count, so the counter never passes DEB_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt <= '0;
      level_q <= 1'b0;
    end else if (sync_q == level_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_MAX) begin
      deb_cnt <= '0;
      level_q <= ~level_q;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Registered press strobe, one cycle after the level rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      press_q <= 1'b0;
    end else begin
      level_d <= level_q;
      press_q <= level_q & ~level_d;
    end
  end

`ifdef HL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_MAX  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_MAX = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RPT} rpt_st_t;

  rpt_st_t          state;
  rpt_st_t          state_nxt;
  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_cnt_nxt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

  // Next state. Level falling or a conflict always parks the FSM in IDLE, so
  // after a conflict clears the surviving button needs a fresh press.
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    if (inhibit || !level_q) begin
      state_nxt   = ST_IDLE;
      rpt_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rpt_cnt_nxt = '0;
          if (press_q) state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (rpt_cnt == DLY_MAX) begin
            state_nxt   = ST_RPT;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        ST_RPT: begin
          if (rpt_cnt == RATE_MAX) rpt_cnt_nxt = '0;
          else                     rpt_cnt_nxt = rpt_cnt + 1'b1;
        end
        default: begin
          state_nxt   = ST_IDLE;
          rpt_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output decode; gating on level suppresses a repeat in the cycle the
  // debounced level has already dropped.
  always_comb begin
    rpt_pulse = 1'b0;
    if (level_q && !inhibit) begin
      if (state == ST_WAIT && rpt_cnt == DLY_MAX) rpt_pulse = 1'b1;
      if (state == ST_RPT  && rpt_cnt == RATE_MAX) rpt_pulse = 1'b1;
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif

  assign level = level_q;
  assign pulse = (press_q | rpt_pulse) & ~inhibit;

endmodule

module hl_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic up_raw,
  input  logic down_raw,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_level,
  output logic down_level,
  output logic conflict
);

  // Counters compare against value-1, so each value must fit in CNT_W bits.
  // An undersized CNT_W shows up as this named block in the elaborated tree.
  if ((DEBOUNCE_CYCLES >= (1 << CNT_W)) || (REPEAT_DELAY >= (1 << CNT_W)) ||
      (REPEAT_RATE >= (1 << CNT_W))) begin : g_cnt_w_too_small
  end

  // Both strobes are gated by conflict, so they can never be high together.
  assign conflict = up_level & down_level;

  hl_btn_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef HL_AUTOREPEAT_EN
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE),
`endif
    .CNT_W           (CNT_W)
  ) u_up (
    .clk     (clk),
    .reset   (reset),
    .raw     (up_raw),
    .inhibit (conflict),
    .level   (up_level),
    .pulse   (up_pulse)
  );

  hl_btn_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef HL_AUTOREPEAT_EN
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE),
`endif
    .CNT_W           (CNT_W)
  ) u_down (
    .clk     (clk),
    .reset   (reset),
    .raw     (down_raw),
    .inhibit (conflict),
    .level   (down_level),
    .pulse   (down_pulse)
  );

endmodule

// File: tb/tb_hl_button_conditioner.sv
// Directed bench for hl_button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_RATE=4. Edge 0 is the clock edge after which a
// stimulus change is applied; expected edges are hand-derived from a
// 2-cycle synchroniser, 4-cycle debounce and 1-cycle press register.
module tb_hl_button_conditioner;

`ifdef HL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic up_raw;
  logic down_raw;
  logic up_pulse;
  logic down_pulse;
  logic up_level;
  logic down_level;
  logic conflict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hl_button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_RATE     (4),
    .CNT_W           (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .up_raw     (up_raw),
    .down_raw   (down_raw),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .up_level   (up_level),
    .down_level (down_level),
    .conflict   (conflict)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %0b expected %0b", tag, e, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag, input int e);
    chk({tag, "_up_pulse"}, e, up_pulse, 1'b0);
    chk({tag, "_down_pulse"}, e, down_pulse, 1'b0);
    chk({tag, "_up_level"}, e, up_level, 1'b0);
    chk({tag, "_down_level"}, e, down_level, 1'b0);
    chk({tag, "_conflict"}, e, conflict, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // 1. Reset held 3 cycles with up_raw high.
    reset    = 1'b1;
    up_raw   = 1'b1;
    down_raw = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all_zero("rst_hold", i);
    end
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("rst_rel_up_pulse", e, up_pulse, e == 7);
      chk("rst_rel_up_level", e, up_level, e >= 6);
    end
    up_raw = 1'b0;
    idle(15);

    // 2. Clean press, held 6 cycles.
    tick();
    up_raw = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk("clean_up_pulse", e, up_pulse, e == 7);
      chk("clean_up_level", e, up_level, e >= 6 && e < 12);
      if (e == 6) up_raw = 1'b0;
    end
    idle(5);

    // 3. Bounce 1,0,1,0 then 0.
    tick();
    up_raw = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk("bounce_up_level", e, up_level, 1'b0);
      chk("bounce_up_pulse", e, up_pulse, 1'b0);
      chk("bounce_conflict", e, conflict, 1'b0);
      if (e == 1) up_raw = 1'b0;
      if (e == 2) up_raw = 1'b1;
      if (e == 3) up_raw = 1'b0;
    end
    idle(5);

    // 4. Long hold, released after edge 30 (level falls at edge 36).
    tick();
    up_raw = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      tick();
      chk("hold_up_pulse", e, up_pulse,
          e == 7 || (AR && (e == 15 || e == 19 || e == 23 || e == 27 || e == 31 || e == 35)));
      chk("hold_up_level", e, up_level, e >= 6 && e < 36);
      chk("hold_down_pulse", e, down_pulse, 1'b0);
      if (e == 30) up_raw = 1'b0;
    end
    idle(5);

    // 5. Conflict: down from edge 0, up from edge 10 to edge 30.
    tick();
    down_raw = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      tick();
      chk("conf_down_pulse", e, down_pulse, e == 7 || (AR && e == 15));
      chk("conf_up_pulse", e, up_pulse, 1'b0);
      chk("conf_conflict", e, conflict, e >= 16 && e < 36);
      chk("conf_down_level", e, down_level, e >= 6);
      if (e == 10) up_raw = 1'b1;
      if (e == 30) up_raw = 1'b0;
    end
    down_raw = 1'b0;
    idle(15);

    // 6. Reset mid-hold, button still held through and after reset.
    tick();
    up_raw = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      chk("mid_pre_up_pulse", e, up_pulse, e == 7 || (AR && e == 15));
    end
    reset = 1'b1;
    #1;
    chk_all_zero("mid_async", 17);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all_zero("mid_hold", i);
    end
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("mid_post_up_pulse", e, up_pulse, e == 7);
      chk("mid_post_up_level", e, up_level, e >= 6);
    end
    up_raw = 1'b0;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
